// File: rtl/rs_ctrl_pkg.sv
// Shared constants for the RS flip-flop command arbiter: FSM encoding, opcodes
// and the pulse-counter width rule.
package rs_ctrl_pkg;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PULSE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    localparam logic OP_SET = 1'b1;
    localparam logic OP_RST = 1'b0;

    // Counter must be able to hold the value PULSE_CYC itself.
    function automatic int cnt_width(input int pulse_cyc);
        return $clog2(pulse_cyc + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searching upward from a
// registered pointer; the pointer moves past the winner when en is high.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         en,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW:0]   cand;
    logic          found;

    always_comb begin
        win   = '0;
        cand  = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            cand = {1'b0, ptr} + (PW+1)'(i);
            if (cand >= (PW+1)'(N)) cand = cand - (PW+1)'(N);
            if (!found && req[cand[PW-1:0]]) begin
                found = 1'b1;
                win   = cand[PW-1:0];
            end
        end
        grant = found ? (N'(1) << win) : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (win == PW'(N - 1)) ? '0 : win + PW'(1);
        end
    end

endmodule

// File: rtl/rs_cmd_arbiter.sv
// Arbitrates set/reset commands from NREQ requesters onto a bank of NFF RS
// flip-flops, never driving s and r together. Define RS_CMD_VERIFY_EN to build the q-readback check.
module rs_cmd_arbiter
    import rs_ctrl_pkg::*;
#(
    parameter int NREQ      = 4,
    parameter int NFF       = 8,
    parameter int PULSE_CYC = 2,
    localparam int IDXW     = $clog2(NFF)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ-1:0]      req_op,
    input  logic [NREQ*IDXW-1:0] req_idx,
    output logic [NREQ-1:0]      req_ready,
    output logic [NFF-1:0]       ff_s,
    output logic [NFF-1:0]       ff_r,
    input  logic [NFF-1:0]       ff_q,
    output logic                 busy,
    output logic                 err
);

    localparam int CW = cnt_width(PULSE_CYC);

    logic [1:0]      state;
    logic            op_q;
    logic [IDXW-1:0] idx_q;
    logic [CW-1:0]   cnt;

    logic [NREQ-1:0] grant;
    logic            xfer;
    logic            win_op;
    logic [IDXW-1:0] win_idx;
    logic [NFF-1:0]  sel_mask;

    // Requests are only presented to the arbiter in IDLE, so grant doubles as req_ready.
    rr_arbiter #(.N(NREQ)) u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req_valid & {NREQ{state == IDLE}}),
        .en    (xfer),
        .grant (grant)
    );

    assign req_ready = grant;
    assign xfer      = |grant;
    assign busy      = (state != IDLE);

    always_comb begin
        win_op  = 1'b0;
        win_idx = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (grant[k]) begin
                win_op  = win_op | req_op[k];
                win_idx = win_idx | req_idx[k*IDXW +: IDXW];
            end
        end
    end

    assign sel_mask = NFF'(1) << win_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ff_s  <= '0;
            ff_r  <= '0;
            op_q  <= 1'b0;
            idx_q <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (xfer) begin
                        op_q  <= win_op;
                        idx_q <= win_idx;
                        cnt   <= CW'(1);
                        if (32'(win_idx) < NFF) begin
                            state <= PULSE;
                            ff_s  <= sel_mask & {NFF{win_op == OP_SET}};
                            ff_r  <= sel_mask & {NFF{win_op == OP_RST}};
                        end else begin
                            state <= SETTLE;
                        end
                    end
                end
                PULSE: begin
                    if (cnt == CW'(PULSE_CYC)) begin
                        ff_s  <= '0;
                        ff_r  <= '0;
                        state <= SETTLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                SETTLE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RS_CMD_VERIFY_EN
    logic idx_in_range;
    assign idx_in_range = (32'(idx_q) < NFF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == SETTLE && (!idx_in_range || ff_q[idx_q] != op_q)) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q;
    assign unused_q = ^ff_q;
    assign err      = 1'b0;
`endif

endmodule

// File: tb/tb_rs_cmd_arbiter.sv
// Bench for rs_cmd_arbiter: directed scenarios then random traffic, checked
// against a transaction-level model of arbitration, pulse timing and error flag.
module tb_rs_cmd_arbiter;

    localparam int NREQ      = 4;
    localparam int NFF       = 6;
    localparam int PULSE_CYC = 2;
    localparam int IDXW      = $clog2(NFF);

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_op = '0;
    logic [NREQ*IDXW-1:0] req_idx = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NFF-1:0]       ff_s, ff_r, ff_q;
    logic [NFF-1:0]       bank = '0;
    logic                 busy, err;
    logic                 corrupt = 1'b0;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int             m_ptr = 0;
    int             m_phase = 0;
    int             m_pulse = 0;
    int             m_idx = 0;
    logic           m_op = 1'b0;
    logic           m_err = 1'b0;
    logic [NFF-1:0] m_q = '0;

    always #5 clk = ~clk;

    // External RS flip-flop bank; optionally bit 2 reads back stuck at 0.
    always @(posedge clk) begin
        for (int b = 0; b < NFF; b++) begin
            if (ff_s[b]) bank[b] <= 1'b1;
            else if (ff_r[b]) bank[b] <= 1'b0;
        end
    end
    assign ff_q = bank & ~(NFF'(corrupt) << 2);

    rs_cmd_arbiter #(.NREQ(NREQ), .NFF(NFF), .PULSE_CYC(PULSE_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .ff_s      (ff_s),
        .ff_r      (ff_r),
        .ff_q      (ff_q),
        .busy      (busy),
        .err       (err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [NREQ-1:0] v, input int ptr);
        for (int k = 0; k < NREQ; k++)
            if (v[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        return -1;
    endfunction

    function automatic logic [NREQ*IDXW-1:0] pack(input int a, input int b, input int c, input int d);
        return {IDXW'(d), IDXW'(c), IDXW'(b), IDXW'(a)};
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        #1;
        check("rst_ff_s", ff_s, 0);
        check("rst_ff_r", ff_r, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        check("rst_ready", req_ready, 0);
        m_ptr   = 0;
        m_phase = 0;
        m_pulse = 0;
        m_err   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: drive, check against model, then advance the model past the edge.
    task automatic cycle(input logic [NREQ-1:0] v, input logic [NREQ-1:0] o,
                         input logic [NREQ*IDXW-1:0] ix);
        int w;
        logic [NFF-1:0] es, er;
        req_valid = v;
        req_op    = o;
        req_idx   = ix;
        #1;
        w  = (m_phase == 0) ? pick(v, m_ptr) : -1;
        es = '0;
        er = '0;
        if (m_pulse > 0) begin
            if (m_op) es[m_idx] = 1'b1;
            else      er[m_idx] = 1'b1;
        end
        check("req_ready", req_ready, (w < 0) ? 0 : (1 << w));
        check("ff_s", ff_s, es);
        check("ff_r", ff_r, er);
        check("busy", busy, m_phase != 0);
        check("err", err, m_err);
        check("s_and_r", |(ff_s & ff_r), 0);
        check("sr_onehot", $countones(ff_s | ff_r) <= 1, 1);
        if (m_phase == 0)
            check("ff_q", ff_q, m_q & ~(NFF'(corrupt) << 2));
        @(posedge clk);
        if (m_phase == 0) begin
            if (w >= 0) begin
                m_ptr = (w + 1) % NREQ;
                m_op  = o[w];
                m_idx = int'(ix[w*IDXW +: IDXW]);
                if (m_idx < NFF) begin
                    m_pulse    = PULSE_CYC;
                    m_phase    = PULSE_CYC + 1;
                    m_q[m_idx] = m_op;
                end else begin
                    m_pulse = 0;
                    m_phase = 1;
                end
            end
        end else begin
`ifdef RS_CMD_VERIFY_EN
            if (m_phase == 1 && (m_idx >= NFF || ff_q[m_idx] !== m_op)) m_err = 1'b1;
`endif
            if (m_pulse > 0) m_pulse--;
            m_phase--;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle('0, '0, '0);
    endtask

    initial begin
        #2;
        do_reset();

        // Single set of bit 3
        cycle(4'b0001, 4'b0001, pack(3, 0, 0, 0));
        idle(5);

        // All four requesters at once from pointer 0
        do_reset();
        for (int i = 0; i < 17; i++) cycle(4'b1111, 4'b0101, pack(0, 1, 3, 4));
        idle(4);

        // Set and reset of the same bit competing
        for (int i = 0; i < 8; i++) cycle(4'b0110, 4'b0010, pack(0, 5, 5, 0));
        idle(4);

        // Read-back of bit 2 stuck low after a set
        corrupt = 1'b1;
        cycle(4'b0001, 4'b0001, pack(2, 0, 0, 0));
        idle(7);
        corrupt = 1'b0;
        idle(2);

        // Reset during the second pulse cycle
        cycle(4'b0100, 4'b0100, pack(0, 0, 1, 0));
        cycle('0, '0, '0);
        do_reset();
        cycle(4'b1111, 4'b1111, pack(4, 3, 2, 1));
        idle(5);

        // Out-of-range index
        cycle(4'b0001, 4'b0001, pack(7, 0, 0, 0));
        idle(4);

        // Random traffic
        for (int i = 0; i < 400; i++)
            cycle(NREQ'($urandom_range(0, 15)), NREQ'($urandom), (NREQ*IDXW)'($urandom));
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
